// File: rtl/lu_serial_sequencer_if.sv
// lu_serial_sequencer_if
//   Bundles the request/response handshake of the serial sequencer together
//   with the bit-level link to the external 1-bit logic unit.
//   Modports:
//     master : requester + logic unit side (drives start/op/a_in/b_in/lu_s)
//     slave  : sequencer side (drives busy/done/result/lu_a/lu_b/lu_sel)
interface lu_serial_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             lu_a;
    logic             lu_b;
    logic [1:0]       lu_sel;
    logic             lu_s;

    modport master (
        output start, op, a_in, b_in, lu_s,
        input  busy, done, result, lu_a, lu_b, lu_sel
    );

    modport slave (
        input  start, op, a_in, b_in, lu_s,
        output busy, done, result, lu_a, lu_b, lu_sel
    );
endinterface

// File: rtl/lu_serial_sequencer.sv
// lu_serial_sequencer
//   Runs a WIDTH-bit OR/NOR/XOR/XNOR operation through an external
//   combinational 1-bit logic unit, one bit per cycle, LSB first. The unit's
//   output is shifted in at the MSB so that after WIDTH shifts bit 0 lands in
//   result[0]. A one-cycle done pulse marks the result valid; it then holds
//   until the next accepted start.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset (aborts any operation, no done)
//     bus   : slave modport of lu_serial_sequencer_if
//             start/op/a_in/b_in in, busy/done/result out,
//             lu_a/lu_b/lu_sel to the unit, lu_s back from it
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; unit inputs parked at 0
//   RUN   | one operand bit per cycle through the unit (WIDTH cycles)
//   DONE  | result valid, done high for exactly this cycle
module lu_serial_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lu_serial_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       op_reg;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] result_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= 2'b00;
            count      <= '0;
            result_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg      <= bus.a_in;
                        b_reg      <= bus.b_in;
                        op_reg     <= bus.op;
                        count      <= '0;
                        result_reg <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    result_reg <= {bus.lu_s, result_reg[WIDTH-1:1]};
                    a_reg      <= {1'b0, a_reg[WIDTH-1:1]};
                    b_reg      <= {1'b0, b_reg[WIDTH-1:1]};
                    count      <= count + CNT_W'(1);
                    // The edge that captures the last bit also leaves RUN.
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // All outputs decode registered state only, so none can glitch on inputs.
    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.result = result_reg;
    assign bus.lu_a   = (state == RUN) ? a_reg[0] : 1'b0;
    assign bus.lu_b   = (state == RUN) ? b_reg[0] : 1'b0;
    assign bus.lu_sel = (state == RUN) ? op_reg : 2'b00;
endmodule

// File: doc/lu_serial_sequencer.md
Name: lu_serial_sequencer

Overview:
Bit-serial controller that sequences the 1-bit OR/NOR/XOR/XNOR logic unit over WIDTH-bit operands. The unit is external and combinational. The block latches two operands and an op code, drives the unit one bit per cycle LSB-first, and shifts the returned bit into a result register. It signals completion with a one-cycle done pulse, so one 1-bit unit can serve word-wide logic operations.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.
CNT_W, $clog2(WIDTH+1), bit counter width; derived, not overridden.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising clk edge, accepted only in IDLE
op  input  2  operation: 00 XNOR, 01 XOR, 10 OR, 11 NOR (unit's select encoding)
a_in  input  WIDTH  operand A, latched on accept
b_in  input  WIDTH  operand B, latched on accept
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
result  output  WIDTH  assembled result
lu_a  output  1  bit to unit input a
lu_b  output  1  bit to unit input b
lu_sel  output  2  select to unit
lu_s  input  1  unit output, same-cycle combinational return

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset (`rst_n`=0, any time, asynchronous):
  - state=IDLE; a_reg, b_reg, result, count=0; op_reg=00.
  - busy=0, done=0, lu_a=0, lu_b=0, lu_sel=00.
  - Reset mid-RUN aborts the operation, with no done pulse.
- State machine: IDLE, RUN, DONE.
  - IDLE: if start=1 at an edge, latch a_in→a_reg, b_in→b_reg, op→op_reg; count=0; result=0; go to RUN.
  - RUN: each edge:
    - result <= {lu_s, result[WIDTH-1:1]}
    - a_reg and b_reg shift right by 1
    - count++
    - when count reaches WIDTH-1 at that edge, go to DONE.
  - DONE: done=1 for this single cycle; next edge goes to IDLE unconditionally.
- Unit drive:
  - In RUN: lu_a=a_reg[0], lu_b=b_reg[0], lu_sel=op_reg.
  - Outside RUN: lu_a=0, lu_b=0, lu_sel=00.
- Output decode: busy = (state==RUN); done = (state==DONE). Both are decoded from registered state, so they are glitch-free w.r.t. inputs.
- Timing, with start accepted at edge t0:
  - busy is high from t0 to t0+WIDTH.
  - Bit i is captured at edge t0+1+i.
  - done is high from t0+WIDTH to t0+WIDTH+1.
- Result validity:
  - result holds its final value from done until the next accepted start.
  - Intermediate values during RUN are partial and not valid.
- Ignored inputs:
  - start in RUN or DONE is ignored; no queueing.
  - a_in, b_in and op changes after accept are ignored.
- Start held high continuously: operations are accepted every WIDTH+2 cycles (DONE, then one IDLE cycle, then accept).

Test Plan:
- Reset: rst_n=0 with start=1 and random inputs → busy=0, done=0, result=8'h00, lu_sel=00, lu_a=lu_b=0. Release → state stays IDLE until start.
- XOR: a_in=8'hA5, b_in=8'h0F, op=01, one-cycle start → busy for 8 cycles, done pulses exactly 8 cycles after accept for 1 cycle, result=8'hAA. lu_sel=01 throughout RUN, and lu_a sequence is 1,0,1,0,0,1,0,1.
- All ops, same operands 8'hA5/8'h0F:
  - op=10 (OR) → 8'hAF
  - op=11 (NOR) → 8'h50
  - op=00 (XNOR) → 8'h55
  - Edge operands: a_in=8'hFF, b_in=8'hFF, op=01 → 8'h00.
- Start while busy: accept XOR 8'hA5/8'h0F, then pulse start at RUN cycle 3 with a_in=8'hFF, op=10 → ignored; result=8'hAA; exactly one done pulse.
- Reset mid-op: accept any op, assert rst_n=0 after 4 RUN cycles → immediate busy=0, result=0, no done. After release, a new start with OR 8'h0F/8'hF0 → 8'hFF.
- Back-to-back: start held high, two ops XOR then OR (operands changed during the first op's DONE cycle) → accepts spaced 10 cycles (WIDTH+2); results 8'hAA then the OR result of the second operand pair.
